mac_mem_ctrl: RTL and testbench
===============================

MAC_MEM_CTRL -- requirements
Module: mac_mem_ctrl

Interface
REQ-001 Parameter ADDR_STRIDE, default 4, byte increment between consecutive row words.
REQ-002 One clock, clk_i; reset rst_i is synchronous and active-high.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 start_i  in  1  launch request from pipeline; sampled only in IDLE.
REQ-006 opcode_i  in  2  MAC operation code, latched at start.
REQ-007 rs1_i / rs2_i / rd_i  in  32 each  base byte address of matrix A, matrix B, result; latched at start.
REQ-008 busy_o  out  1  high whenever state != IDLE.
REQ-009 done_o  out  1  single-cycle completion pulse.
REQ-010 mem_req_o, mem_we_o  out  1 each  memory request / write enable.
REQ-011 mem_addr_o, mem_wdata_o  out  32 each  word address / write data.
REQ-012 mem_rdata_i  in  32  read data, valid when mem_ack_i=1 on a read.
REQ-013 mem_ack_i  in  1  access complete; may arrive in the same cycle as mem_req_o or any later cycle.
REQ-014 mac_opcode_o  out  2  latched opcode to MAC datapath.
REQ-015 mac_a_o / mac_b_o  out  96 each  {row0,row1,row2} operand words, row0 in [95:64].
REQ-016 mac_res_i  in  96  {res0,res1,res2} combinational MAC result, res0 in [95:64].

Function
REQ-017 States IDLE, RD_A, RD_B, COMPUTE, WR, DONE; 2-bit row index idx (0..2).
REQ-018 IDLE & start_i: latch opcode_i, rs1_i, rs2_i, rd_i with bits [1:0] cleared; idx=0; go RD_A. start_i outside IDLE is ignored.
REQ-019 RD_A/RD_B: mem_req_o=1, mem_we_o=0, mem_addr_o = base + idx*ADDR_STRIDE (mod 2^32).
REQ-020 On mem_ack_i in a read state, capture mem_rdata_i into operand word idx; if idx==2 then idx=0 and advance (RD_A->RD_B, RD_B->COMPUTE), else idx++.
REQ-021 Without mem_ack_i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o hold stable; no state change.
REQ-022 COMPUTE lasts exactly one cycle: register mac_res_i into three result words; go WR.
REQ-023 WR: mem_req_o=1, mem_we_o=1, mem_addr_o = rd + idx*ADDR_STRIDE, mem_wdata_o = result word idx; on ack, idx==2 -> DONE else idx++.
REQ-024 DONE: done_o=1 for one cycle; next state IDLE unconditionally.
REQ-025 mem_req_o=0, mem_we_o=0 in IDLE, COMPUTE, DONE; mem_ack_i ignored when mem_req_o=0.
REQ-026 mac_a_o, mac_b_o, mac_opcode_o driven from registers, stable from end of RD_B through next start.
REQ-027 Zero-wait memory (ack same cycle as req): start sampled at edge T -> done_o high in cycle T+11 (3 RD_A, 3 RD_B, 1 COMPUTE, 3 WR, 1 DONE), IDLE at T+12.
REQ-028 Each wait cycle on any access extends latency by exactly one cycle.
REQ-029 Base near 0xFFFF_FFFC wraps modulo 2^32 without error.
REQ-030 No writes issued before all six reads acknowledged; exactly three writes per operation.

Reset
REQ-031 rst_i=1 at any edge: state IDLE, idx=0, all latched addresses, opcode, operand and result registers 0.
REQ-032 During/after reset: busy_o=0, done_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mac_a_o=0, mac_b_o=0, mac_opcode_o=0.
REQ-033 Reset mid-operation abandons the transfer; mem_req_o low the cycle after the reset edge; no done_o pulse for the aborted operation.

Verification
REQ-034 Zero-wait: rs1=0x100, rs2=0x200, rd=0x300, opcode=1 -> reads 0x100,0x104,0x108,0x200,0x204,0x208, writes 0x300,0x304,0x308 with res0..res2, done_o at T+11.
REQ-035 Ack delayed 2 cycles on every access -> addr/wdata stable while waiting, done_o at T+29.
REQ-036 rs1=0x103 -> reads at 0x100,0x104,0x108; rd=0xFFFFFFF8 -> writes 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-037 start_i held high throughout -> exactly one operation per IDLE visit; second launch sampled at T+12.
REQ-038 rst_i asserted during second WR beat -> mem_req_o=0 next cycle, busy_o=0, no done_o, third write never issued.

Source files
------------

// File: rtl/mac_mem_ctrl.sv
// Sequences a 3-row matrix MAC: fetch A and B rows from memory, register the
// combinational MAC result for one cycle, then write the three result words back.
module mac_mem_ctrl #(
    parameter int unsigned ADDR_STRIDE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  opcode_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rd_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [1:0]  mac_opcode_o,
    output logic [95:0] mac_a_o,
    output logic [95:0] mac_b_o,
    input  logic [95:0] mac_res_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_COMPUTE,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  opcode_q, opcode_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] rd_q, rd_d;
    logic [95:0] a_q, a_d;
    logic [95:0] b_q, b_d;
    logic [95:0] res_q, res_d;

    logic [31:0] offset;
    logic        last_row;

    // Row 0 lives in the top word of each 96-bit operand vector.
    function automatic logic [95:0] put_word(input logic [95:0] vec,
                                             input logic [1:0]  idx,
                                             input logic [31:0] word);
        logic [95:0] r;
        r = vec;
        case (idx)
            2'd0:    r[95:64] = word;
            2'd1:    r[63:32] = word;
            default: r[31:0]  = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [95:0] vec,
                                             input logic [1:0]  idx);
        logic [31:0] r;
        case (idx)
            2'd0:    r = vec[95:64];
            2'd1:    r = vec[63:32];
            default: r = vec[31:0];
        endcase
        return r;
    endfunction

    assign offset   = 32'(idx_q) * 32'(ADDR_STRIDE);
    assign last_row = (idx_q == 2'd2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            opcode_q <= 2'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            rd_q     <= 32'd0;
            a_q      <= 96'd0;
            b_q      <= 96'd0;
            res_q    <= 96'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opcode_q <= opcode_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opcode_d = opcode_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    opcode_d = opcode_i;
                    rs1_d    = {rs1_i[31:2], 2'b00};
                    rs2_d    = {rs2_i[31:2], 2'b00};
                    rd_d     = {rd_i[31:2], 2'b00};
                    idx_d    = 2'd0;
                    state_d  = S_RD_A;
                end
            end
            S_RD_A: begin
                if (mem_ack_i) begin
                    a_d = put_word(a_q, idx_q, mem_rdata_i);
                    if (last_row) begin
                        idx_d   = 2'd0;
                        state_d = S_RD_B;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_RD_B: begin
                if (mem_ack_i) begin
                    b_d = put_word(b_q, idx_q, mem_rdata_i);
                    if (last_row) begin
                        idx_d   = 2'd0;
                        state_d = S_COMPUTE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_COMPUTE: begin
                res_d   = mac_res_i;
                state_d = S_WR;
            end
            S_WR: begin
                if (mem_ack_i) begin
                    if (last_row) begin
                        idx_d   = 2'd0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are a pure function of registered state, so they hold
    // steady for as long as the memory withholds its ack.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        case (state_q)
            S_RD_A: begin
                mem_req_o  = 1'b1;
                mem_addr_o = rs1_q + offset;
            end
            S_RD_B: begin
                mem_req_o  = 1'b1;
                mem_addr_o = rs2_q + offset;
            end
            S_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = rd_q + offset;
                mem_wdata_o = get_word(res_q, idx_q);
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign mac_opcode_o = opcode_q;
    assign mac_a_o      = a_q;
    assign mac_b_o      = b_q;

endmodule

// File: tb/tb_mac_mem_ctrl.sv
// Self-checking bench for mac_mem_ctrl: memory responder with programmable
// wait states, a stand-in MAC datapath, and an access-list reference model.
module tb_mac_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  opcode = 2'd0;
    logic [31:0] rs1 = 32'd0, rs2 = 32'd0, rd = 32'd0;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [1:0]  mac_op;
    logic [95:0] mac_a, mac_b, mac_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_mem_ctrl #(.ADDR_STRIDE(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .opcode_i(opcode),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .busy_o(busy), .done_o(done),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .mac_opcode_o(mac_op), .mac_a_o(mac_a), .mac_b_o(mac_b),
        .mac_res_i(mac_res)
    );

    logic [31:0] salt = 32'h1234_5678;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [31:0] mac_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        return (a * b) + 32'(op);
    endfunction

    assign mac_res = {mac_f(mac_a[95:64], mac_b[95:64], mac_op),
                      mac_f(mac_a[63:32], mac_b[63:32], mac_op),
                      mac_f(mac_a[31:0],  mac_b[31:0],  mac_op)};

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: every access is logged when acked.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t log_q[$];

    int          wait_mode = 0;
    int          cur_wait = 0;
    int          wcnt = 0;
    int          total_waits = 0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    always @(negedge clk) begin
        if (mem_ack || !mem_req) wcnt = 0;
        mem_ack = 1'b0;
        if (mem_req && !rst) begin
            if (wcnt == 0) begin
                cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                h_addr   = mem_addr;
                h_wdata  = mem_wdata;
                h_we     = mem_we;
            end else begin
                chk("hold_addr", 96'(mem_addr), 96'(h_addr));
                chk("hold_wdata", 96'(mem_wdata), 96'(h_wdata));
                chk("hold_we", 96'(mem_we), 96'(h_we));
            end
            if (wcnt >= cur_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 32'hDEAD_BEEF : mem_val(mem_addr);
                log_q.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
            end else begin
                wcnt++;
                total_waits++;
            end
        end
    end

    task automatic do_op(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] rdd,
                         input logic [1:0] op, input int wm, input bit hold, output int lat);
        log_q.delete();
        total_waits = 0;
        wait_mode   = wm;
        salt        = $urandom;
        @(negedge clk);
        start  = 1'b1;
        rs1    = r1;
        rs2    = r2;
        rd     = rdd;
        opcode = op;
        @(posedge clk);
        #1;
        if (!hold) begin
            start  = 1'b0;
            rs1    = $urandom;
            rs2    = $urandom;
            rd     = $urandom;
            opcode = 2'($urandom);
        end
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (lat > 300) begin
                chk("done_timeout", 96'(done), 96'd1);
                break;
            end
        end
    endtask

    // ea lists the nine expected addresses in bus order: 3 A reads, 3 B reads, 3 writes.
    task automatic verify(input logic [0:8][31:0] ea, input logic [1:0] op,
                          input int lat, input int exp_lat);
        logic [95:0] ea_vec, eb_vec;
        chk("latency", 96'(lat), 96'(exp_lat));
        chk("n_access", 96'(log_q.size()), 96'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < log_q.size()) begin
                chk($sformatf("addr[%0d]", i), 96'(log_q[i].addr), 96'(ea[i]));
                chk($sformatf("we[%0d]", i), 96'(log_q[i].we), (i >= 6) ? 96'd1 : 96'd0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (6 + k < log_q.size())
                chk($sformatf("wdata[%0d]", k), 96'(log_q[6+k].data),
                    96'(mac_f(mem_val(ea[k]), mem_val(ea[3+k]), op)));
        end
        ea_vec = {mem_val(ea[0]), mem_val(ea[1]), mem_val(ea[2])};
        eb_vec = {mem_val(ea[3]), mem_val(ea[4]), mem_val(ea[5])};
        chk("mac_a", mac_a, ea_vec);
        chk("mac_b", mac_b, eb_vec);
        chk("mac_op", 96'(mac_op), 96'(op));
        @(negedge clk);
        chk("done_pulse_len", 96'(done), 96'd0);
        chk("idle_after_done", 96'(busy), 96'd0);
    endtask

    typedef struct {
        logic [31:0]      r1, r2, rdd;
        logic [1:0]       op;
        int               wm;
        logic [0:8][31:0] ea;
        int               exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int               lat, lat2, n_done, n_req;
        logic [31:0]      r1, r2, rdd, b1, b2, b3;
        logic [1:0]       op;
        logic [0:8][31:0] ea;

        vecs[0] = '{32'h100, 32'h200, 32'h300, 2'd1, 0,
                    {32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208,
                     32'h300, 32'h304, 32'h308}, 11};
        vecs[1] = '{32'h100, 32'h200, 32'h300, 2'd1, 2,
                    {32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208,
                     32'h300, 32'h304, 32'h308}, 29};
        vecs[2] = '{32'h103, 32'h200, 32'hFFFF_FFF8, 2'd2, 0,
                    {32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208,
                     32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0}, 11};
        vecs[3] = '{32'hFFFF_FFFE, 32'h7, 32'h10, 2'd3, 1,
                    {32'hFFFF_FFFC, 32'h0, 32'h4, 32'h4, 32'h8, 32'hC,
                     32'h10, 32'h14, 32'h18}, 20};

        repeat (3) @(negedge clk);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_done", 96'(done), 96'd0);
        chk("rst_req", 96'(mem_req), 96'd0);
        chk("rst_we", 96'(mem_we), 96'd0);
        chk("rst_addr", 96'(mem_addr), 96'd0);
        chk("rst_wdata", 96'(mem_wdata), 96'd0);
        chk("rst_mac_a", mac_a, 96'd0);
        chk("rst_mac_b", mac_b, 96'd0);
        chk("rst_mac_op", 96'(mac_op), 96'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 4; v++) begin
            do_op(vecs[v].r1, vecs[v].r2, vecs[v].rdd, vecs[v].op, vecs[v].wm, 1'b0, lat);
            verify(vecs[v].ea, vecs[v].op, lat, vecs[v].exp_lat);
        end

        // Random operations with random per-access wait states.
        for (int n = 0; n < 12; n++) begin
            r1  = $urandom;
            r2  = $urandom;
            rdd = $urandom;
            if ($urandom_range(0, 2) == 0) r1  = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) rdd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            op = 2'($urandom);
            do_op(r1, r2, rdd, op, -1, 1'b0, lat);
            b1 = r1 & 32'hFFFF_FFFC;
            b2 = r2 & 32'hFFFF_FFFC;
            b3 = rdd & 32'hFFFF_FFFC;
            for (int k = 0; k < 3; k++) begin
                ea[k]   = b1 + 32'(4 * k);
                ea[3+k] = b2 + 32'(4 * k);
                ea[6+k] = b3 + 32'(4 * k);
            end
            verify(ea, op, lat, 11 + total_waits);
        end

        // start held high: one op per IDLE visit, relaunch sampled at the end of cycle 12.
        do_op(32'h40, 32'h80, 32'hC0, 2'd0, 0, 1'b1, lat);
        verify(vecs[0].ea ^ vecs[0].ea | {32'h40, 32'h44, 32'h48, 32'h80, 32'h84, 32'h88,
                                          32'hC0, 32'hC4, 32'hC8}, 2'd0, lat, 11);
        @(negedge clk);
        chk("hold_relaunch_busy", 96'(busy), 96'd1);
        lat2 = 1;
        while (!done && lat2 < 300) begin
            @(negedge clk);
            lat2++;
        end
        start = 1'b0;
        chk("hold_second_latency", 96'(lat2), 96'd11);
        chk("hold_total_access", 96'(log_q.size()), 96'd18);
        repeat (3) @(negedge clk);
        chk("hold_idle_after_release", 96'(busy), 96'd0);

        // Reset during the second write beat.
        log_q.delete();
        wait_mode = 5;
        @(negedge clk);
        start = 1'b1; rs1 = 32'h400; rs2 = 32'h500; rd = 32'h600; opcode = 2'd2;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (log_q.size() < 7 && lat < 300) begin
            @(negedge clk);
            #1;
            lat++;
        end
        repeat (2) @(negedge clk);
        chk("rst_mid_we", 96'(mem_we), 96'd1);
        chk("rst_mid_addr", 96'(mem_addr), 96'h604);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", 96'(mem_req), 96'd0);
        chk("rst_mid_busy", 96'(busy), 96'd0);
        chk("rst_mid_mac_a", mac_a, 96'd0);
        chk("rst_mid_mac_op", 96'(mac_op), 96'd0);
        rst = 1'b0;
        n_done = 0;
        n_req  = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
            if (mem_req) n_req++;
        end
        chk("rst_mid_no_done", 96'(n_done), 96'd0);
        chk("rst_mid_no_req", 96'(n_req), 96'd0);
        chk("rst_mid_writes", 96'(log_q.size()), 96'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
